emoji_blit: RTL and testbench

Sprite blitter sitting directly downstream of `emoji_rom`. On a `start` pulse it raster-scans the 64x64 emoji sprite and drives `pixel_x`/`pixel_y` into the ROM. It captures the registered RGB565 `rgb_data` and streams the pixels, tagged with screen coordinates, to the display writer over a valid/ready handshake. The sprite is clipped to the screen; a 4-entry credit-managed FIFO absorbs the ROM latency so the stream sustains 1 pixel/cycle under back-pressure.

---
 rtl/emoji_blit.sv | 165 ++++++++++++++++
 tb/tb_emoji_blit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/emoji_blit.sv
// Sprite blitter: raster-scans the 64x64 emoji ROM, clips to the screen and
// streams tagged RGB565 pixels over valid/ready through a credit-managed FIFO.
module emoji_blit #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int XW       = 9,
  parameter int YW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  output logic          busy,
  output logic          done,
  output logic [5:0]    rom_x,
  output logic [5:0]    rom_y,
  input  logic [15:0]   rom_rgb,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [15:0]   pix_rgb,
  output logic          pix_last
);

  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam int TW  = XW + YW + 1;
  localparam int EW  = 16 + TW;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [XW-1:0]   x0_q;
  logic [YW-1:0]   y0_q;
  logic [5:0]      vw_m1, vh_m1;
  logic            s1_valid, s2_valid;
  logic [TW-1:0]   s1_tag, s2_tag;
  logic [EW-1:0]   mem [4];
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      count;

  logic [XW:0]     rem_x;
  logic [YW:0]     rem_y;
  logic            clip_all;
  logic [5:0]      vw_m1_in, vh_m1_in;
  logic            pop, push, credit_ok, issue, issue_first;
  logic [3:0]      used;
  logic            at_row_end, nx_last;
  logic [5:0]      nx_x, nx_y;
  logic [EW-1:0]   head;

  // Visible extent of the sprite for the requested origin
  always_comb begin
    rem_x    = XW1'(SCREEN_W) - {1'b0, x0};
    rem_y    = YW1'(SCREEN_H) - {1'b0, y0};
    clip_all = ({1'b0, x0} >= XW1'(SCREEN_W)) || ({1'b0, y0} >= YW1'(SCREEN_H));
    vw_m1_in = (rem_x >= XW1'(64)) ? 6'd63 : 6'(rem_x - 1'b1);
    vh_m1_in = (rem_y >= YW1'(64)) ? 6'd63 : 6'(rem_y - 1'b1);
  end

  // Slots committed after this edge: stored entries plus reads still in the ROM path
  assign pop       = pix_valid & pix_ready;
  assign push      = s2_valid;
  assign used      = 4'(count) + 4'(s1_valid) + 4'(s2_valid) - 4'(pop);
  assign credit_ok = used < 4'd4;

  assign at_row_end = (rom_x == vw_m1);
  assign nx_x       = at_row_end ? 6'd0 : rom_x + 6'd1;
  assign nx_y       = at_row_end ? rom_y + 6'd1 : rom_y;
  assign nx_last    = (nx_x == vw_m1) && (nx_y == vh_m1);

  always_comb begin
    state_nx    = state;
    issue       = 1'b0;
    issue_first = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (clip_all) begin
            state_nx = DONE;
          end else begin
            issue_first = 1'b1;
            state_nx    = (vw_m1_in == 6'd0 && vh_m1_in == 6'd0) ? DRAIN : SCAN;
          end
        end
      end
      SCAN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (nx_last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid && used == 4'd0) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      vw_m1    <= '0;
      vh_m1    <= '0;
      rom_x    <= '0;
      rom_y    <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_tag   <= '0;
      s2_tag   <= '0;
    end else begin
      state    <= state_nx;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      s1_valid <= 1'b0;
      if (issue_first) begin
        x0_q     <= x0;
        y0_q     <= y0;
        vw_m1    <= vw_m1_in;
        vh_m1    <= vh_m1_in;
        rom_x    <= 6'd0;
        rom_y    <= 6'd0;
        s1_valid <= 1'b1;
        s1_tag   <= {x0, y0, (vw_m1_in == 6'd0 && vh_m1_in == 6'd0)};
      end else if (issue) begin
        rom_x    <= nx_x;
        rom_y    <= nx_y;
        s1_valid <= 1'b1;
        s1_tag   <= {x0_q + XW'(nx_x), y0_q + YW'(nx_y), nx_last};
      end
    end
  end

  // Tag leaving the pipeline is paired with the ROM word it addressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {rom_rgb, s2_tag};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign pix_valid = (count != 3'd0);
  assign pix_rgb   = pix_valid ? head[EW-1 -: 16] : '0;
  assign pix_x     = pix_valid ? head[TW-1 -: XW] : '0;
  assign pix_y     = pix_valid ? head[YW:1] : '0;
  assign pix_last  = pix_valid ? head[0] : 1'b0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_emoji_blit.sv
// Directed bench for emoji_blit: table of blits checked against a raster
// scoreboard and ROM model, plus reset-abort and restart sequences.
module tb_emoji_blit;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic          busy, done;
  logic [5:0]    rom_x, rom_y;
  logic [15:0]   rom_rgb = '0;
  logic          pix_valid, pix_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [15:0]   pix_rgb;
  logic          pix_last;

  int total = 0;
  int bad = 0;

  emoji_blit #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
    .busy(busy), .done(done), .rom_x(rom_x), .rom_y(rom_y), .rom_rgb(rom_rgb),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_model(input logic [5:0] x, input logic [5:0] y);
    if (x == 6'd18 && y == 6'd3) return 16'hFFE0;
    if (x == 6'd8 && y == 6'd17) return 16'hF800;
    return {x, y, x[3:0] ^ y[3:0]};
  endfunction

  // Registered ROM: data follows the sampled address by one edge
  always @(posedge clk) rom_rgb <= rom_model(rom_x, rom_y);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    int            duty;
    bit            mid_start;
    int            exp_n;
    int            exp_lx;
    int            exp_ly;
  } vec_t;

  task automatic applyStimulus(input logic [XW-1:0] sx0, input logic [YW-1:0] sy0,
                               input int duty, input bit mid_start, input int exp_n,
                               input int exp_lx, input int exp_ly);
    int vw, vh, ex, ey, got, first_valid_k, last_hs_k, done_k, done_cnt, lx, ly;
    bit finished, prev_stall, exp_last;
    logic [XW+YW+16:0] prev_bus, cur_bus, exp_bus;
    if (int'(sx0) >= SCREEN_W || int'(sy0) >= SCREEN_H) begin
      vw = 0;
      vh = 0;
    end else begin
      vw = (SCREEN_W - int'(sx0) < 64) ? SCREEN_W - int'(sx0) : 64;
      vh = (SCREEN_H - int'(sy0) < 64) ? SCREEN_H - int'(sy0) : 64;
    end
    ex = 0; ey = 0; got = 0; lx = -1; ly = -1;
    first_valid_k = -1; last_hs_k = -1; done_k = -1; done_cnt = 0;
    finished = 0; prev_stall = 0; prev_bus = '0;
    @(negedge clk);
    x0 = sx0; y0 = sy0; start = 1'b1; pix_ready = 1'b0;
    for (int k = 0; k < BUDGET && !finished; k++) begin
      @(negedge clk);
      start = mid_start && (k == 100);
      if (start) begin
        x0 = '0;
        y0 = '0;
      end
      pix_ready = (duty >= 10) ? 1'b1 : ($urandom_range(0, 9) < duty);
      cur_bus = {pix_x, pix_y, pix_rgb, pix_last};
      if (k == 0) begin
        checkOutput("busy_after_start", busy, 1);
        if (vw > 0) checkOutput("first_addr", {rom_x, rom_y}, 12'h000);
      end
      if (prev_stall) checkOutput("stall_hold", {pix_valid, cur_bus}, {1'b1, prev_bus});
      if (pix_valid && first_valid_k < 0) first_valid_k = k;
      if (pix_valid && pix_ready) begin
        exp_last = (ex == vw - 1) && (ey == vh - 1);
        exp_bus = {XW'(int'(sx0) + ex), YW'(int'(sy0) + ey), rom_model(6'(ex), 6'(ey)), exp_last};
        if (got < vw * vh) checkOutput("pixel", cur_bus, exp_bus);
        if (ex == 0 && ey == 0)  checkOutput("rgb_0_0", pix_rgb, 16'h0000);
        if (ex == 18 && ey == 3) checkOutput("rgb_18_3", pix_rgb, 16'hFFE0);
        if (ex == 8 && ey == 17) checkOutput("rgb_8_17", pix_rgb, 16'hF800);
        got++;
        lx = int'(pix_x);
        ly = int'(pix_y);
        last_hs_k = k;
        if (ex == vw - 1) begin
          ex = 0;
          ey++;
        end else begin
          ex++;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k == done_k + 1) begin
        checkOutput("busy_after_done", busy, 0);
        finished = 1;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_bus = cur_bus;
    end
    checkOutput("blit_finished", finished, 1);
    checkOutput("pixel_count", got, exp_n);
    checkOutput("done_pulses", done_cnt, 1);
    if (exp_n > 0) begin
      checkOutput("last_coord", {lx, ly}, {exp_lx, exp_ly});
      checkOutput("done_after_last", done_k, last_hs_k + 1);
      if (duty >= 10) begin
        checkOutput("first_valid_cycle", first_valid_k, 2);
        checkOutput("last_hs_cycle", last_hs_k, exp_n + 1);
      end
    end else begin
      checkOutput("clip_done_cycle", done_k, 0);
      checkOutput("clip_no_valid", first_valid_k, -1);
    end
  endtask

  vec_t vecs[5];
  int   done_seen, valid_seen;

  initial begin
    vecs[0] = '{x0: 9'd0,   y0: 8'd0,   duty: 10, mid_start: 0, exp_n: 4096, exp_lx: 63,  exp_ly: 63};
    vecs[1] = '{x0: 9'd300, y0: 8'd220, duty: 10, mid_start: 0, exp_n: 400,  exp_lx: 319, exp_ly: 239};
    vecs[2] = '{x0: 9'd320, y0: 8'd10,  duty: 10, mid_start: 0, exp_n: 0,    exp_lx: 0,   exp_ly: 0};
    vecs[3] = '{x0: 9'd100, y0: 8'd50,  duty: 3,  mid_start: 0, exp_n: 4096, exp_lx: 163, exp_ly: 113};
    vecs[4] = '{x0: 9'd300, y0: 8'd220, duty: 10, mid_start: 1, exp_n: 400,  exp_lx: 319, exp_ly: 239};

    rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ctrl", {busy, done, pix_valid, pix_last}, 4'h0);
    checkOutput("reset_rom_addr", {rom_x, rom_y}, 12'h000);
    checkOutput("reset_pix", {pix_x, pix_y, pix_rgb}, '0);

    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[i].x0, vecs[i].y0, vecs[i].duty, vecs[i].mid_start,
                    vecs[i].exp_n, vecs[i].exp_lx, vecs[i].exp_ly);

    // Abort a blit mid-scan with reset, then run a fresh one
    @(negedge clk);
    x0 = '0; y0 = '0; start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_ctrl", {busy, done, pix_valid, pix_last}, 4'h0);
    checkOutput("abort_rom_addr", {rom_x, rom_y}, 12'h000);
    checkOutput("abort_pix", {pix_x, pix_y, pix_rgb}, '0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    valid_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) done_seen++;
      if (pix_valid || busy) valid_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    checkOutput("abort_quiet", valid_seen, 0);
    applyStimulus(9'd310, 8'd200, 10, 0, 400, 319, 239);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
